// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
//   - 2-bit saturating counter encodings and the values written on allocation.
//   - sat_update(): next counter state for a resolved branch that hit.
//   - cnt_taken(): prediction carried by a counter value.
package bp_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;   // strong not-taken
    localparam logic [1:0] CNT_WNT = 2'b01;   // weak not-taken
    localparam logic [1:0] CNT_WT  = 2'b10;   // weak taken
    localparam logic [1:0] CNT_ST  = 2'b11;   // strong taken

    // A freshly allocated line starts in the weak state of the observed outcome.
    localparam logic [1:0] ALLOC_T  = CNT_WT;
    localparam logic [1:0] ALLOC_NT = CNT_WNT;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end else begin
            return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
        end
    endfunction

    // The upper half of the encoding predicts taken.
    function automatic logic cnt_taken(input logic [1:0] cnt);
        return (cnt >= CNT_WT);
    endfunction

endpackage

// File: rtl/bp_cache.sv
// Direct-mapped tagged cache with two combinational read ports and one write port.
//   clk, reset      : clock, asynchronous active-high reset (invalidates all lines)
//   ra0/dout0/hit0  : read port 0 (address, data, hit), combinational
//   ra1/dout1/hit1  : read port 1 (address, data, hit), combinational
//   we/wa/din       : write port, committed at the rising edge when we = 1
// The line index is the low log2(LINES) address bits; the remaining bits are the tag.
// LINES must be a power of two.
module bp_cache #(
    parameter int AWIDTH = 32,
    parameter int LINES  = 128,
    parameter int DWIDTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] ra0,
    output logic [DWIDTH-1:0] dout0,
    output logic              hit0,
    input  logic [AWIDTH-1:0] ra1,
    output logic [DWIDTH-1:0] dout1,
    output logic              hit1,
    input  logic              we,
    input  logic [AWIDTH-1:0] wa,
    input  logic [DWIDTH-1:0] din
);

    localparam int IW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int TW = AWIDTH - IW;

    logic [LINES-1:0]  valid_q;
    logic [TW-1:0]     tag_q  [LINES];
    logic [DWIDTH-1:0] data_q [LINES];

    logic [IW-1:0] idx0, idx1, widx;

    assign idx0 = ra0[IW-1:0];
    assign idx1 = ra1[IW-1:0];
    assign widx = wa[IW-1:0];

    assign hit0  = valid_q[idx0] && (tag_q[idx0] == ra0[AWIDTH-1:IW]);
    assign dout0 = data_q[idx0];
    assign hit1  = valid_q[idx1] && (tag_q[idx1] == ra1[AWIDTH-1:IW]);
    assign dout1 = data_q[idx1];

    // Only the valid bits need reset; tag/data contents are ignored while invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[widx]  <= wa[AWIDTH-1:IW];
            data_q[widx] <= din;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Branch predictor built around bp_cache holding 2-bit saturating counters.
//   clk, reset        : clock, asynchronous active-high reset
//   pc_guess          : fetch PC, looked up on cache read port 0
//   is_br_guess       : fetched instruction is a conditional branch
//   br_pred_taken     : combinational prediction for pc_guess
//   pc_check          : PC of the branch resolving this cycle
//   is_br_check       : a conditional branch resolves this cycle
//   br_taken_check    : actual outcome of that branch
//   br_count          : resolved branches applied to the table
//   br_mispred_count  : updates whose pre-update prediction was wrong
// A resolved branch is captured at the edge ending its cycle (stage C) and
// written back during the following cycle (stage U) via read port 1 and the
// write port. The guess path forwards the counter being written so that a
// fetch of the same PC during stage U sees the new value.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int LINES     = 128,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PC_WIDTH-1:0]  pc_guess,
    input  logic                 is_br_guess,
    output logic                 br_pred_taken,
    input  logic [PC_WIDTH-1:0]  pc_check,
    input  logic                 is_br_check,
    input  logic                 br_taken_check,
    output logic [CNT_WIDTH-1:0] br_count,
    output logic [CNT_WIDTH-1:0] br_mispred_count
);

    logic                 upd_valid_q, upd_valid_d;
    logic [PC_WIDTH-1:0]  upd_pc_q, upd_pc_d;
    logic                 upd_taken_q, upd_taken_d;
    logic [CNT_WIDTH-1:0] br_count_q, br_count_d;
    logic [CNT_WIDTH-1:0] br_mispred_q, br_mispred_d;

    logic [1:0] dout0, dout1, next_cnt;
    logic       hit0, hit1;
    logic       old_pred, bypass, guess_bit;

    bp_cache #(
        .AWIDTH (PC_WIDTH),
        .LINES  (LINES),
        .DWIDTH (2)
    ) u_cache (
        .clk   (clk),
        .reset (reset),
        .ra0   (pc_guess),
        .dout0 (dout0),
        .hit0  (hit0),
        .ra1   (upd_pc_q),
        .dout1 (dout1),
        .hit1  (hit1),
        .we    (upd_valid_q),
        .wa    (upd_pc_q),
        .din   (next_cnt)
    );

    // Stage U: counter to write back. A miss allocates (and may evict).
    always_comb begin
        next_cnt = upd_taken_q ? ALLOC_T : ALLOC_NT;
        if (hit1) begin
            next_cnt = sat_update(dout1, upd_taken_q);
        end
    end

    // Prediction the table held for the updating branch before this write.
    assign old_pred = hit1 && cnt_taken(dout1);

    // Guess path with forwarding of the in-flight write.
    assign bypass        = upd_valid_q && (pc_guess == upd_pc_q);
    assign guess_bit     = bypass ? cnt_taken(next_cnt) : (hit0 && cnt_taken(dout0));
    assign br_pred_taken = is_br_guess && guess_bit;

    always_comb begin
        upd_valid_d  = is_br_check;
        upd_pc_d     = pc_check;
        upd_taken_d  = br_taken_check;
        br_count_d   = br_count_q;
        br_mispred_d = br_mispred_q;
        if (upd_valid_q) begin
            br_count_d = br_count_q + CNT_WIDTH'(1);
            if (old_pred != upd_taken_q) begin
                br_mispred_d = br_mispred_q + CNT_WIDTH'(1);
            end
        end
    end

    // Stage C capture and statistics. Reset drops any pending stage-U write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_valid_q  <= 1'b0;
            upd_pc_q     <= '0;
            upd_taken_q  <= 1'b0;
            br_count_q   <= '0;
            br_mispred_q <= '0;
        end else begin
            upd_valid_q  <= upd_valid_d;
            upd_pc_q     <= upd_pc_d;
            upd_taken_q  <= upd_taken_d;
            br_count_q   <= br_count_d;
            br_mispred_q <= br_mispred_d;
        end
    end

    assign br_count         = br_count_q;
    assign br_mispred_count = br_mispred_q;

endmodule
